// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter, registered RF write port and per-register busy scoreboard.
// Optional macro RF_ARB_FIXED_PRIO_EN: req0 always wins ties (no round-robin state).
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_stall,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic                  gnt0;
    logic                  gnt1;
    logic                  wen_q,   wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]       busy_q,  busy_d;
    logic                  issue_fire;

`ifdef RF_ARB_FIXED_PRIO_EN
    assign gnt0 = !rst && req0_valid;
    assign gnt1 = !rst && req1_valid && !req0_valid;
`else
    // last_grant_q = 1 means req1 was granted most recently, so req0 wins the next tie.
    logic last_grant_q, last_grant_d;

    assign gnt0 = !rst && req0_valid && (!req1_valid || last_grant_q);
    assign gnt1 = !rst && req1_valid && (!req0_valid || !last_grant_q);

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0)
            last_grant_d = 1'b0;
        else if (gnt1)
            last_grant_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant_q <= 1'b1;
        else
            last_grant_q <= last_grant_d;
    end
`endif

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Writes to x0 are accepted but never raise the write enable.
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (gnt0) begin
            wen_d   = (req0_addr != '0);
            waddr_d = req0_addr;
            wdata_d = req0_data;
        end else if (gnt1) begin
            wen_d   = (req1_addr != '0);
            waddr_d = req1_addr;
            wdata_d = req1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Gating with rst drops a pending write the moment reset is raised.
    assign rf_wen   = wen_q && !rst;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

    assign issue_stall = !rst && issue_valid &&
                         (busy_q[issue_rs1] || busy_q[issue_rs2] || busy_q[issue_rd]);
    assign issue_fire  = issue_valid && !issue_stall;

    // Clear first so a same-index set on the same edge takes precedence.
    always_comb begin
        busy_d = busy_q;
        if (rf_wen)
            busy_d[rf_waddr] = 1'b0;
        if (issue_fire && (issue_rd != '0))
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

endmodule
